// File: rtl/ext_fifo_unit.sv
// ext_fifo_unit: widens an IN_W operand to OUT_W (zero, sign, LSB-replicate,
// upper-load) and buffers the result in a DEPTH-entry valid/ready FIFO.
// Optional macro EXT_FIFO_CNT_EN adds beat_cnt and mode_hist statistics.
module ext_fifo_unit #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_mode
`ifdef EXT_FIFO_CNT_EN
   ,
   output logic [15:0]      beat_cnt,
   output logic [3:0]       mode_hist
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   generate
      if (IN_W < 1 || IN_W > OUT_W || DEPTH < 1) begin : g_param_check
         $error("ext_fifo_unit: need 1 <= IN_W <= OUT_W and DEPTH >= 1");
      end
   endgenerate

   logic [OUT_W-1:0] ext_word;
   logic [OUT_W-1:0] data_mem [DEPTH];
   logic [1:0]       mode_mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = data_mem[rd_ptr];
   assign out_mode  = mode_mem[rd_ptr];

   // Operand extension; written as overlays so IN_W == OUT_W needs no zero-width fill.
   always_comb begin
      ext_word = '0;
      case (in_mode)
         2'b00: ext_word[IN_W-1:0] = in_data;
         2'b01: begin
            ext_word = {OUT_W{in_data[IN_W-1]}};
            ext_word[IN_W-1:0] = in_data;
         end
         2'b10: ext_word = {OUT_W{in_data[0]}};
         default: ext_word[OUT_W-1 -: IN_W] = in_data;
      endcase
   end

   // Pointer and occupancy bookkeeping; flush overrides any same-cycle push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            data_mem[i] <= '0;
            mode_mem[i] <= '0;
         end
      end else if (push && !flush) begin
         data_mem[wr_ptr] <= ext_word;
         mode_mem[wr_ptr] <= in_mode;
      end
   end

`ifdef EXT_FIFO_CNT_EN
   // Push statistics; only reset clears them, discarded (flushed) beats do not count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         mode_hist <= '0;
      end else if (push && !flush) begin
         beat_cnt           <= beat_cnt + 16'd1;
         mode_hist[in_mode] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ext_fifo_unit.sv
// Bench for ext_fifo_unit: three instances (16->32 depth 2, 16->32 depth 3,
// 8->8 depth 2) share one stimulus; a queue model checks every cycle and
// directed literal expectations pin the model. Build with EXT_FIFO_CNT_EN to
// also cover the statistics outputs.
module tb_ext_fifo_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_ready;

   logic        rdy2, vld2, rdy3, vld3, rdy8, vld8;
   logic [31:0] dat2, dat3;
   logic [7:0]  dat8;
   logic [1:0]  md2, md3, md8;
`ifdef EXT_FIFO_CNT_EN
   logic [15:0] bc2, bc3, bc8;
   logic [3:0]  mh2, mh3, mh8;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ext_fifo_unit #(.IN_W(16), .OUT_W(32), .DEPTH(2)) u2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
      .in_data(in_data), .in_mode(in_mode), .out_valid(vld2), .out_ready(out_ready),
      .out_data(dat2), .out_mode(md2)
`ifdef EXT_FIFO_CNT_EN
      , .beat_cnt(bc2), .mode_hist(mh2)
`endif
   );

   ext_fifo_unit #(.IN_W(16), .OUT_W(32), .DEPTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
      .in_data(in_data), .in_mode(in_mode), .out_valid(vld3), .out_ready(out_ready),
      .out_data(dat3), .out_mode(md3)
`ifdef EXT_FIFO_CNT_EN
      , .beat_cnt(bc3), .mode_hist(mh3)
`endif
   );

   ext_fifo_unit #(.IN_W(8), .OUT_W(8), .DEPTH(2)) u8 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy8),
      .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(vld8), .out_ready(out_ready),
      .out_data(dat8), .out_mode(md8)
`ifdef EXT_FIFO_CNT_EN
      , .beat_cnt(bc8), .mode_hist(mh8)
`endif
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  m;
   } ent_t;

   ent_t q [3][$];
   int   dep [3] = '{2, 3, 2};
   int   inw [3] = '{16, 16, 8};
   int   outw[3] = '{32, 32, 8};
   int   cnt8 = 0;
   logic [3:0] hist8 = '0;

   function automatic logic [31:0] ext_model(input logic [15:0] d, input logic [1:0] m,
                                             input int iw, input int ow);
      longint unsigned mi, mo, v, r;
      mi = (64'd1 << iw) - 1;
      mo = (64'd1 << ow) - 1;
      v  = {48'd0, d} & mi;
      case (m)
         2'd0:    r = v;
         2'd1:    r = v[iw-1] ? (v | (mo & ~mi)) : v;
         2'd2:    r = v[0] ? mo : 64'd0;
         default: r = (v << (ow - iw)) & mo;
      endcase
      return r[31:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) q[i].delete();
         cnt8  = 0;
         hist8 = '0;
      end else if (flush) begin
         for (int i = 0; i < 3; i++) q[i].delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            bit pu, po;
            ent_t e;
            pu = in_valid && (q[i].size() < dep[i]);
            po = out_ready && (q[i].size() > 0);
            if (po) void'(q[i].pop_front());
            if (pu) begin
               e.d = ext_model(in_data, in_mode, inw[i], outw[i]);
               e.m = in_mode;
               q[i].push_back(e);
               if (i == 2) begin
                  cnt8 = (cnt8 + 1) % 65536;
                  hist8[in_mode] = 1'b1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int i, input logic rdy, input logic vld,
                           input logic [31:0] dat, input logic [1:0] md);
      check($sformatf("u%0d.in_ready", i), {63'd0, rdy}, (q[i].size() < dep[i]) ? 64'd1 : 64'd0);
      check($sformatf("u%0d.out_valid", i), {63'd0, vld}, (q[i].size() != 0) ? 64'd1 : 64'd0);
      if (q[i].size() != 0) begin
         check($sformatf("u%0d.out_data", i), {32'd0, dat}, {32'd0, q[i][0].d});
         check($sformatf("u%0d.out_mode", i), {62'd0, md}, {62'd0, q[i][0].m});
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      cmp_inst(0, rdy2, vld2, dat2, md2);
      cmp_inst(1, rdy3, vld3, dat3, md3);
      cmp_inst(2, rdy8, vld8, {24'd0, dat8}, md8);
`ifdef EXT_FIFO_CNT_EN
      check("u8.beat_cnt", {48'd0, bc8}, cnt8);
      check("u8.mode_hist", {60'd0, mh8}, {60'd0, hist8});
`endif
   end

   // ---------------- directed stimulus ----------------
   logic [15:0] m_dat [5] = '{16'h8001, 16'h8001, 16'h0003, 16'h0002, 16'h1234};
   logic [1:0]  m_mod [5] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
   logic [31:0] m_exp [5] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFFFF, 32'h00000000, 32'h12340000};
   logic [7:0]  c_dat [5] = '{8'h81, 8'h81, 8'h7F, 8'hA5, 8'h3C};
   logic [1:0]  c_mod [5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0};

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.out_valid", {63'd0, vld2}, 64'd0);
      check("reset.in_ready", {63'd0, rdy2}, 64'd1);
      check("reset.out_data", {32'd0, dat2}, 64'd0);
      check("reset.out_mode", {62'd0, md2}, 64'd0);
      #3 rst_n = 1'b1;
      @(negedge clk);

      // Mode stream with out_ready=1: each result visible one edge after its push.
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = m_dat[k]; in_mode = m_mod[k];
         @(negedge clk);
         check($sformatf("mode%0d.u2", k), {32'd0, dat2}, {32'd0, m_exp[k]});
         check($sformatf("mode%0d.u3", k), {32'd0, dat3}, {32'd0, m_exp[k]});
         check($sformatf("mode%0d.u2.count1", k), {63'd0, rdy2}, 64'd1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("mode.drained", {63'd0, vld2}, 64'd0);

      // Backpressure: A,B accepted, C held until space opens.
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_data = 16'h0001;
      @(negedge clk);
      in_data = 16'h0002;
      @(negedge clk);
      check("bp.full_ready", {63'd0, rdy2}, 64'd0);
      in_data = 16'h0003;
      repeat (3) @(negedge clk);
      check("bp.held_ready", {63'd0, rdy2}, 64'd0);
      check("bp.head_A", {32'd0, dat2}, 64'h1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp.head_B", {32'd0, dat2}, 64'h2);
      @(negedge clk);
      check("bp.head_C", {32'd0, dat2}, 64'h3);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("bp.empty", {63'd0, vld2}, 64'd0);

      // Flush at count=2 with a beat offered in the same cycle.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
      @(negedge clk);
      in_data = 16'h0022;
      @(negedge clk);
      in_data = 16'h0033; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check("flush.out_valid", {63'd0, vld2}, 64'd0);
      check("flush.in_ready", {63'd0, rdy2}, 64'd1);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0044;
      @(negedge clk);
      check("flush.next_beat", {32'd0, dat2}, 64'h44);
      in_valid = 1'b0;
      @(negedge clk);
      check("flush.empty", {63'd0, vld2}, 64'd0);

      // Asynchronous reset between edges while entries are buffered.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
      @(negedge clk);
      in_data = 16'h0066;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst.out_valid", {63'd0, vld2}, 64'd0);
      check("arst.out_data", {32'd0, dat2}, 64'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00FF; in_mode = 2'd1;
      @(negedge clk);
      check("arst.post_push", {32'd0, dat2}, 64'h000000FF);
      in_valid = 1'b0;
      @(negedge clk);

      // Fresh reset, then the 8->8 sequence for the statistics outputs.
      @(posedge clk);
      #3 rst_n = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = {8'h00, c_dat[k]}; in_mode = c_mod[k];
         @(negedge clk);
         check($sformatf("w8.beat%0d", k), {56'd0, dat8}, {56'd0, c_dat[k]});
      end
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
`ifdef EXT_FIFO_CNT_EN
      check("cnt.beat_cnt", {48'd0, bc8}, 64'd5);
      check("cnt.mode_hist", {60'd0, mh8}, 64'hB);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ext_fifo_unit.md
Name: ext_fifo_unit

Overview:
- Parametrised, registered successor to the fixed 1-to-32-bit replicator.
- Widens an IN_W operand to OUT_W using one of four modes: zero-extend, sign-extend, LSB-replicate or upper-load (LUI-style).
- Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the decode stage (immediate/flag source) and the ALU operand mux, decoupling decode stalls from execute stalls.

Parameters:
- IN_W, 16, input operand width; 1 <= IN_W <= OUT_W.
- OUT_W, 32, output word width.
- DEPTH, 2, FIFO entries; >= 1; need not be a power of two.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  producer has a valid operand.
- in_ready  out  1  unit can accept a beat this cycle.
- in_data  in  IN_W  operand.
- in_mode  in  2  00 zero, 01 sign, 10 replicate in_data[0], 11 upper-load.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  OUT_W  extended result at FIFO head.
- out_mode  out  2  mode tag carried with the head entry.

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately clears count, read/write pointers and out_valid. in_ready=1 while reset is deasserted and count=0. out_data and out_mode reset to 0.
- Extension is combinational on in_data and in_mode, and is written into the FIFO on push:
  - 00: {(OUT_W-IN_W) zeros, in_data}.
  - 01: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
  - 10: OUT_W copies of in_data[0]; all other bits are ignored.
  - 11: {in_data, (OUT_W-IN_W) zeros}.
  - When IN_W==OUT_W, modes 00, 01 and 11 all yield in_data unchanged.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from out_ready. A full FIFO therefore does not accept a beat in the same cycle as a pop.
- Latency: a beat pushed at edge N is visible on out_valid/out_data after edge N (1 cycle). There is no combinational in-to-out path.
- out_valid = (count != 0). out_data/out_mode are driven from the head entry.
- While out_valid=1 and out_ready=0, the head entry holds stable.
- Entries leave in strict FIFO order.
- Count update per edge:
  - push & !pop: +1.
  - pop & !push: -1.
  - both: unchanged, with head and tail pointers both advancing.
  - neither: unchanged.
- Pointers wrap at DEPTH-1 -> 0 for any DEPTH, not only powers of two.
- flush=1 at an edge: count and both pointers go to 0.
  - Any push or pop in that same cycle is discarded.
  - in_ready is still shown as 1 if not full, but the beat is dropped; producers must not drive in_valid during flush.
- Reset asserted mid-transfer discards all entries immediately, with no partial state retained.
- Elaboration must fail if IN_W > OUT_W or DEPTH < 1.

Optional Feature:
- Macro EXT_FIFO_CNT_EN.
- When defined:
  - Adds output beat_cnt [15:0]: number of pushes since reset, wrapping 0xFFFF -> 0x0000.
  - Adds output mode_hist [3:0]: sticky bit per mode seen on any push.
  - Both are cleared by rst_n only; flush does not clear them.
  - Both are registered and update at the edge of the push.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan (IN_W=16, OUT_W=32, DEPTH=2 unless stated):
- Modes, out_ready=1:
  - push 0x8001 mode 01 -> 0xFFFF8001.
  - push 0x8001 mode 00 -> 0x00008001.
  - push 0x0003 mode 10 -> 0xFFFFFFFF.
  - push 0x0002 mode 10 -> 0x00000000.
  - push 0x1234 mode 11 -> 0x12340000.
  - Each result appears one cycle after its push.
- Backpressure: out_ready=0, offer A=0x0001, B=0x0002, C=0x0003 in mode 00 -> A and B accepted, in_ready=0 after the 2nd push, C held. Raise out_ready -> outputs A, B, C in order, with no loss or duplication.
- Simultaneous push/pop at count=1 -> count stays 1; the pushed value appears right after the popped one. Repeat across pointer wrap with DEPTH=3.
- flush with in_valid=1 at count=2 -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle beat never appears.
- rst_n low asynchronously mid-burst (between edges) -> out_valid drops before the next edge. After release, a push of 0x00FF mode 01 -> 0x000000FF.
- With EXT_FIFO_CNT_EN and IN_W=OUT_W=8: push 5 beats in modes 00, 01, 01, 11, 00, plus a flush -> beat_cnt=5, mode_hist=4'b1011; mode 11 output equals in_data.
